simplez_cpu: RTL
================

// Module: simplez_cpu
// PURPOSE
//  Initiator side of the Simplez 12-bit memory interface: a minimal accumulator CPU.
//  - Fetches instructions from the 512x12 word memory.
//  - Executes them, and issues reads/writes on the shared addr/wr/data bus.
//  - Pairs with the memory block: memory registers read data and performs writes on negedge clk.
//  - This block works on posedge clk only.
// PARAMETERS
//  RESET_PC   9'o000   PC value loaded on reset (first instruction address)
// PORTS
//  clk        in   1   system clock; all state updates on posedge
//  rstn       in   1   synchronous reset, active low
//  mem_addr   out  9   memory address (combinational from state, PC, IR)
//  mem_wr     out  1   memory write strobe; memory writes at next negedge
//  mem_wdata  out  12  write data to memory (always = AC)
//  mem_rdata  in   12  read data from memory; valid at posedge following address cycle
//  halt       out  1   1 while in HALTED state
//  ac_out     out  12  accumulator value, for LEDs/debug
//  pc_out     out  9   program counter, for debug
// BEHAVIOUR
//  Registers
//  - PC[8:0], IR[11:0], AC[11:0], state.
//  - Reset (rstn=0 at posedge): PC<=RESET_PC, IR<=0, AC<=0, state<=FETCH.
//  - Reset outputs: halt=0, ac_out=0, pc_out=RESET_PC.
//  - mem_wr is gated with rstn: forced 0 whenever rstn=0, even mid-instruction, so no write lands during reset.
//  Instruction format
//  - IR[11:9] = opcode CO; IR[8:0] = operand address CD.
//  - Opcodes:
//    0 ST    M[CD]<=AC
//    1 LD    AC<=M[CD]
//    2 ADD   AC<=AC+M[CD]
//    3 BR    PC<=CD
//    4 BZ    if AC==0 PC<=CD
//    5 CLR   AC<=0
//    6 DEC   AC<=AC-1
//    7 HALT
//  State machine: FETCH, EXEC, HALTED
//  - FETCH:
//    - mem_addr=PC, mem_wr=0.
//    - Memory latches M[PC] on the negedge; at posedge IR<=mem_rdata, PC<=PC+1 (mod 512), ->EXEC.
//  - EXEC (opcode from IR):
//    - ST: mem_addr=CD, mem_wr=1, mem_wdata=AC; AC unchanged; ->FETCH.
//    - LD: mem_addr=CD, mem_wr=0; at posedge AC<=mem_rdata; ->FETCH.
//    - ADD: mem_addr=CD; at posedge AC<=(AC+mem_rdata) mod 4096, no carry kept; ->FETCH.
//    - BR: PC<=CD; ->FETCH.
//    - BZ: PC<=CD only if AC==12'o0000, else PC unchanged; ->FETCH.
//    - CLR: AC<=0; ->FETCH.
//    - DEC: AC<=(AC-1) mod 4096 (12'o0000 -> 12'o7777); ->FETCH.
//    - HALT: ->HALTED; PC not changed further.
//    - Non-memory opcodes drive mem_addr=CD, mem_wr=0 (read is harmless).
//  - HALTED:
//    - mem_addr=PC, mem_wr=0, halt=1.
//    - All registers frozen; only rstn=0 leaves (->FETCH).
//  Timing
//  - Every instruction takes exactly 2 cycles (FETCH+EXEC), including ST/LD/ADD.
//  - mem_wr is high only in an EXEC cycle of ST, for exactly one cycle.
//  Boundary cases
//  - PC wraps 9'o777 -> 9'o000 on fetch.
//  - ST followed by a fetch from the same address returns the new data: the write lands at the negedge before the fetch cycle.
//  - Reset asserted during EXEC of ST: no write; next state FETCH at RESET_PC.
// TESTING
//  1. Memory preload {0:1006, 1:0100, 2:7000, 6:0001}, release rstn
//     -> after 6 cycles halt=1, AC=0001, M[0100]=0001, PC=003.
//  2. Program {LD 10, ADD 11, ST 12, HALT}, M[10]=7777, M[11]=0002
//     -> AC=0001 (wrap), M[12]=0001, halt after 8 cycles.
//  3. Program {CLR, DEC, BZ 7, HALT}
//     -> AC=7777, BZ not taken, halt at PC=004;
//     same with DEC replaced by CLR -> branch to 7.
//  4. BR loop at 9'o777 with mem[777]=3000 (BR 0)
//     -> PC wraps 777->000, then fetch from 000; check pc_out each cycle.
//  5. Assert rstn=0 during EXEC of ST 100
//     -> mem_wr=0 that cycle, M[100] unchanged, PC=RESET_PC, AC=0.
//  6. While halted, toggle mem_rdata randomly for 20 cycles
//     -> AC, PC, IR unchanged; mem_wr stays 0; halt stays 1.

Source files
------------

// File: rtl/simplez_cpu.sv
// Simplez accumulator CPU: fetches, decodes and executes 12-bit instructions against a 512x12 memory.
// Latency: every instruction takes two cycles (FETCH then EXEC); HALT parks the core until reset.
// Backpressure: none; memory must return read data at the posedge after the address cycle.
module simplez_cpu #(
    parameter logic [8:0] RESET_PC = 9'o000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic [8:0]  mem_addr,
    output logic        mem_wr,
    output logic [11:0] mem_wdata,
    input  logic [11:0] mem_rdata,
    output logic        halt,
    output logic [11:0] ac_out,
    output logic [8:0]  pc_out
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_EXEC   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [2:0] OP_ST   = 3'd0;
    localparam logic [2:0] OP_LD   = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_BR   = 3'd3;
    localparam logic [2:0] OP_BZ   = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_DEC  = 3'd6;
    localparam logic [2:0] OP_HALT = 3'd7;

    state_t      state, state_nx;
    logic [8:0]  pc, pc_nx;
    logic [11:0] ir, ir_nx;
    logic [11:0] ac, ac_nx;
    logic        wr_raw;
    logic [2:0]  co;
    logic [8:0]  cd;

    assign co = ir[11:9];
    assign cd = ir[8:0];

    // Architectural state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 12'o0000;
            ac    <= 12'o0000;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            ir    <= ir_nx;
            ac    <= ac_nx;
        end
    end

    // Next-state, register updates and bus drive for the fetch/execute cycle.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        ir_nx    = ir;
        ac_nx    = ac;
        mem_addr = pc;
        wr_raw   = 1'b0;
        halt     = 1'b0;
        unique case (state)
            S_FETCH: begin
                ir_nx    = mem_rdata;
                pc_nx    = pc + 9'd1;
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                // Every opcode puts CD on the bus; a read for non-memory ops is harmless.
                mem_addr = cd;
                state_nx = S_FETCH;
                unique case (co)
                    OP_ST:   wr_raw = 1'b1;
                    OP_LD:   ac_nx = mem_rdata;
                    OP_ADD:  ac_nx = ac + mem_rdata;
                    OP_BR:   pc_nx = cd;
                    OP_BZ:   if (ac == 12'o0000) pc_nx = cd;
                    OP_CLR:  ac_nx = 12'o0000;
                    OP_DEC:  ac_nx = ac - 12'd1;
                    OP_HALT: state_nx = S_HALTED;
                    default: state_nx = S_FETCH;
                endcase
            end
            S_HALTED: begin
                halt = 1'b1;
            end
            default: state_nx = S_FETCH;
        endcase
    end

    // Write strobe is masked by reset so an interrupted ST never lands.
    assign mem_wr    = wr_raw & rstn;
    assign mem_wdata = ac;
    assign ac_out    = ac;
    assign pc_out    = pc;

endmodule
